// File: rtl/keyplay_if.sv
// keyplay_if: key strobe/code input and pad drive/status outputs of the playback driver.
interface keyplay_if #(parameter int DEPTH = 8);
  logic strobe;
  logic [4:0] code;
  logic [19:0] out;
  logic busy;
  logic full;
  logic [$clog2(DEPTH):0] level;
  logic err;
  modport master (output strobe, code, input out, busy, full, level, err);
  modport slave (input strobe, code, output out, busy, full, level, err);
endinterface

// File: rtl/keyplay.sv
// keyplay: FIFO-buffered key playback as timed one-hot pad drive; KEYPLAY_ERR_EN adds the sticky err flag.
module keyplay #(
  parameter int ON_CYCLES = 50,
  parameter int OFF_CYCLES = 10,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  keyplay_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int MAXC = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [19:0] out;
  logic strobe_q;
  logic [AW:0] level;
  logic [AW-1:0] wptr, rptr;
  logic [4:0] mem [DEPTH];
  logic push_req, valid, full, push, pop;
  assign push_req = bus.strobe & ~strobe_q;
  assign valid = bus.code < 5'd20;
  assign full = level == (AW+1)'(DEPTH);
  // a full FIFO refuses pushes even when a pop frees a slot on the same edge
  assign push = push_req & valid & ~full;
  assign pop = state == IDLE && level != '0;
  assign bus.out = out;
  assign bus.full = full;
  assign bus.level = level;
  assign bus.busy = state != IDLE || level != '0;
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.code;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      state <= IDLE;
      cnt <= '0;
      out <= '0;
    end else begin
      strobe_q <= bus.strobe;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE: begin
          if (pop) begin
            out <= 20'(1) << mem[rptr];
            cnt <= CW'(ON_CYCLES - 1);
            state <= ON;
          end else out <= '0;
        end
        ON: begin
          if (cnt == '0) begin
            out <= '0;
            cnt <= CW'(OFF_CYCLES - 1);
            state <= GAP;
          end else cnt <= cnt - CW'(1);
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef KEYPLAY_ERR_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_q | (push_req & (~valid | full));
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule
